regfile_port_arbiter: RTL and testbench

- Owns the single memory-side port of the 16x16 register file: memory_index, memory_load, memory_load_en, memory_store.
- Shares that port between instruction fetch (writes IR = reg 0), the load/store unit (LSU) and an optional debug port.
- Keeps a scoreboard of registers reserved by in-flight LSU loads and raises an ALU hazard stall when the ALU touches one.

---
 rtl/regarb_pkg.sv | 19 +
 rtl/regarb_scoreboard.sv | 47 ++++
 rtl/regfile_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regarb_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 16;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [WORD_W-1:0] reg_word_t;

  localparam reg_idx_t IR_IDX = IDX_W'(0);

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_FETCH,
    REQ_LSU,
    REQ_DBG
  } req_id_e;

endpackage

// File: rtl/regarb_scoreboard.sv
// Busy mask of registers reserved by in-flight loads, plus the ALU hazard compare.
module regarb_scoreboard
  import regarb_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned IW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic [IW-1:0]    i_set_idx,
  input  logic             i_clr,
  input  logic [IW-1:0]    i_clr_idx,
  input  logic [IW-1:0]    i_rs1,
  input  logic [IW-1:0]    i_rs2,
  input  logic [IW-1:0]    i_rd,
  output logic [NREGS-1:0] o_busy,
  output logic             o_stall
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_hit_rd;

  // Set is applied after clear so a same-cycle reserve wins; IR never reads as busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set) w_busy_nxt[i_set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign w_hit_rs1 = (i_rs1 != IW'(IR_IDX)) && r_busy[i_rs1];
  assign w_hit_rs2 = (i_rs2 != IW'(IR_IDX)) && r_busy[i_rs2];
  assign w_hit_rd  = (i_rd  != IW'(IR_IDX)) && r_busy[i_rd];

  assign o_busy  = r_busy;
  assign o_stall = w_hit_rs1 | w_hit_rs2 | w_hit_rd;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file memory port between fetch (IR writes), the LSU and,
// when REGARB_DEBUG_PORT_EN is defined, a debug port; tracks load reservations.
module regfile_port_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [DW-1:0]            fetch_wdata,
  output logic                     fetch_gnt,
  input  logic                     lsu_req,
  input  logic                     lsu_we,
  input  logic [$clog2(NREGS)-1:0] lsu_idx,
  input  logic [DW-1:0]            lsu_wdata,
  output logic                     lsu_gnt,
  output logic [DW-1:0]            lsu_rdata,
  output logic                     lsu_rvalid,
  output logic                     lsu_err,
  input  logic                     lsu_rsv,
  input  logic [$clog2(NREGS)-1:0] lsu_rsv_idx,
  input  logic [$clog2(NREGS)-1:0] alu_rs1_i,
  input  logic [$clog2(NREGS)-1:0] alu_rs2_i,
  input  logic [$clog2(NREGS)-1:0] alu_rd_i,
  output logic                     alu_stall,
  output logic [NREGS-1:0]         busy,
`ifdef REGARB_DEBUG_PORT_EN
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [$clog2(NREGS)-1:0] dbg_idx,
  input  logic [DW-1:0]            dbg_wdata,
  output logic                     dbg_gnt,
  output logic [DW-1:0]            dbg_rdata,
  output logic                     dbg_rvalid,
`endif
  output logic [$clog2(NREGS)-1:0] mem_index,
  output logic [DW-1:0]            mem_load,
  output logic                     mem_load_en,
  input  logic [DW-1:0]            mem_store
);

  localparam int unsigned IW = $clog2(NREGS);

  req_id_e       w_gnt_id;
  logic          w_second_req;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic          w_lsu_wr_gnt;
  logic          w_lsu_rd_gnt;

  logic          r_last_fetch;
  logic [IW-1:0] r_mem_index;
  logic [DW-1:0] r_mem_load;
  logic [DW-1:0] r_lsu_rdata;
  logic          r_lsu_rvalid;
  logic          r_lsu_err;
`ifdef REGARB_DEBUG_PORT_EN
  logic          r_rr_lsu;
  logic [DW-1:0] r_dbg_rdata;
  logic          r_dbg_rvalid;
`endif

  // Fetch wins unless it was granted last cycle and someone else is waiting.
  always_comb begin
    w_gnt_id     = REQ_NONE;
    w_second_req = lsu_req;
`ifdef REGARB_DEBUG_PORT_EN
    w_second_req = lsu_req | dbg_req;
`endif
    if (rst)                                                w_gnt_id = REQ_NONE;
    else if (fetch_req && !(r_last_fetch && w_second_req)) w_gnt_id = REQ_FETCH;
`ifdef REGARB_DEBUG_PORT_EN
    else if (lsu_req && (r_rr_lsu || !dbg_req))            w_gnt_id = REQ_LSU;
    else if (dbg_req)                                      w_gnt_id = REQ_DBG;
`else
    else if (lsu_req)                                      w_gnt_id = REQ_LSU;
`endif
  end

  // Port mux; LSU writes to IR are granted but suppressed.
  always_comb begin
    w_idx   = r_mem_index;
    w_wdata = r_mem_load;
    w_we    = 1'b0;
    case (w_gnt_id)
      REQ_FETCH: begin
        w_idx   = IW'(IR_IDX);
        w_wdata = fetch_wdata;
        w_we    = 1'b1;
      end
      REQ_LSU: begin
        w_idx   = lsu_idx;
        w_wdata = lsu_wdata;
        w_we    = lsu_we && (lsu_idx != IW'(IR_IDX));
      end
`ifdef REGARB_DEBUG_PORT_EN
      REQ_DBG: begin
        w_idx   = dbg_idx;
        w_wdata = dbg_wdata;
        w_we    = dbg_we;
      end
`endif
      default: ;
    endcase
  end

  assign fetch_gnt    = (w_gnt_id == REQ_FETCH);
  assign lsu_gnt      = (w_gnt_id == REQ_LSU);
  assign w_lsu_wr_gnt = lsu_gnt & lsu_we;
  assign w_lsu_rd_gnt = lsu_gnt & ~lsu_we;

  assign mem_index   = w_idx;
  assign mem_load    = w_wdata;
  assign mem_load_en = w_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_fetch <= 1'b0;
      r_mem_index  <= '0;
      r_mem_load   <= '0;
      r_lsu_rdata  <= '0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_err    <= 1'b0;
    end else begin
      r_last_fetch <= fetch_gnt;
      r_mem_index  <= w_idx;
      r_mem_load   <= w_wdata;
      r_lsu_rvalid <= w_lsu_rd_gnt;
      r_lsu_err    <= w_lsu_wr_gnt && (lsu_idx == IW'(IR_IDX));
      if (w_lsu_rd_gnt) r_lsu_rdata <= mem_store;
    end
  end

  assign lsu_rdata  = r_lsu_rdata;
  assign lsu_rvalid = r_lsu_rvalid;
  assign lsu_err    = r_lsu_err;

`ifdef REGARB_DEBUG_PORT_EN
  // Round-robin pointer points at whichever of LSU/debug was not served last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_lsu     <= 1'b1;
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      if (lsu_gnt)      r_rr_lsu <= 1'b0;
      else if (dbg_gnt) r_rr_lsu <= 1'b1;
      r_dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) r_dbg_rdata <= mem_store;
    end
  end

  assign dbg_gnt    = (w_gnt_id == REQ_DBG);
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
`endif

  regarb_scoreboard #(
    .NREGS (NREGS),
    .IW    (IW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set     (lsu_rsv),
    .i_set_idx (lsu_rsv_idx),
    .i_clr     (w_lsu_wr_gnt),
    .i_clr_idx (lsu_idx),
    .i_rs1     (alu_rs1_i),
    .i_rs2     (alu_rs2_i),
    .i_rd      (alu_rd_i),
    .o_busy    (busy),
    .o_stall   (alu_stall)
  );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: directed stimulus pushes expected
// grants/read data into queues, a negedge monitor pops and compares them.
module tb_regfile_port_arbiter;
  import regarb_pkg::*;

  typedef struct {
    req_id_e   id;
    reg_idx_t  idx;
    logic      en;
    reg_word_t load;
    logic      rd;
    logic      err;
  } gnt_exp_t;

  gnt_exp_t  q_gnt[$];
  reg_word_t q_rd[$];
  reg_word_t q_drd[$];
  int checks = 0;
  int errors = 0;

  logic      clk = 1'b0;
  logic      rst;
  logic      fetch_req;
  reg_word_t fetch_wdata;
  logic      fetch_gnt;
  logic      lsu_req;
  logic      lsu_we;
  reg_idx_t  lsu_idx;
  reg_word_t lsu_wdata;
  logic      lsu_gnt;
  reg_word_t lsu_rdata;
  logic      lsu_rvalid;
  logic      lsu_err;
  logic      lsu_rsv;
  reg_idx_t  lsu_rsv_idx;
  reg_idx_t  alu_rs1_i;
  reg_idx_t  alu_rs2_i;
  reg_idx_t  alu_rd_i;
  logic      alu_stall;
  logic [15:0] busy;
  reg_idx_t  mem_index;
  reg_word_t mem_load;
  logic      mem_load_en;
  reg_word_t mem_store;
  logic      dbg_gnt;
  reg_word_t dbg_rdata;
  logic      dbg_rvalid;
`ifdef REGARB_DEBUG_PORT_EN
  logic      dbg_req;
  logic      dbg_we;
  reg_idx_t  dbg_idx;
  reg_word_t dbg_wdata;
`else
  assign dbg_gnt    = 1'b0;
  assign dbg_rdata  = '0;
  assign dbg_rvalid = 1'b0;
`endif

  regfile_port_arbiter #(.NREGS(16), .DW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_wdata (fetch_wdata),
    .fetch_gnt   (fetch_gnt),
    .lsu_req     (lsu_req),
    .lsu_we      (lsu_we),
    .lsu_idx     (lsu_idx),
    .lsu_wdata   (lsu_wdata),
    .lsu_gnt     (lsu_gnt),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_err     (lsu_err),
    .lsu_rsv     (lsu_rsv),
    .lsu_rsv_idx (lsu_rsv_idx),
    .alu_rs1_i   (alu_rs1_i),
    .alu_rs2_i   (alu_rs2_i),
    .alu_rd_i    (alu_rd_i),
    .alu_stall   (alu_stall),
    .busy        (busy),
`ifdef REGARB_DEBUG_PORT_EN
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_idx     (dbg_idx),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rdata   (dbg_rdata),
    .dbg_rvalid  (dbg_rvalid),
`endif
    .mem_index   (mem_index),
    .mem_load    (mem_load),
    .mem_load_en (mem_load_en),
    .mem_store   (mem_store)
  );

  always #5 clk = ~clk;

  // Register file model behind the memory port.
  reg_word_t rf [16];
  assign mem_store = rf[mem_index];
  always @(posedge clk) if (mem_load_en) rf[mem_index] <= mem_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input req_id_e id, input reg_idx_t idx, input logic en,
                         input reg_word_t load, input logic rd, input logic err);
    gnt_exp_t e;
    e.id = id; e.idx = idx; e.en = en; e.load = load; e.rd = rd; e.err = err;
    q_gnt.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT grants or returns data.
  logic pend_rv = 1'b0, pend_err = 1'b0, pend_drv = 1'b0;
  always @(negedge clk) begin
    gnt_exp_t e;
    req_id_e  act_id;
    int       ngnt;
    if (rst) begin
      pend_rv = 1'b0; pend_err = 1'b0; pend_drv = 1'b0;
    end else begin
      if (pend_rv || lsu_rvalid) begin
        check("lsu_rvalid", 32'(lsu_rvalid), 32'(pend_rv));
        if (lsu_rvalid) begin
          if (q_rd.size() == 0) check("lsu_rdata_unexpected", 32'(lsu_rdata), 32'hFFFF_FFFF);
          else check("lsu_rdata", 32'(lsu_rdata), 32'(q_rd.pop_front()));
        end
      end
      if (pend_drv || dbg_rvalid) begin
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(pend_drv));
        if (dbg_rvalid) begin
          if (q_drd.size() == 0) check("dbg_rdata_unexpected", 32'(dbg_rdata), 32'hFFFF_FFFF);
          else check("dbg_rdata", 32'(dbg_rdata), 32'(q_drd.pop_front()));
        end
      end
      if (pend_err || lsu_err) check("lsu_err", 32'(lsu_err), 32'(pend_err));
      pend_rv = 1'b0; pend_err = 1'b0; pend_drv = 1'b0;
      ngnt = int'(fetch_gnt) + int'(lsu_gnt) + int'(dbg_gnt);
      if (ngnt != 0) begin
        check("one_gnt", 32'(ngnt), 32'd1);
        act_id = fetch_gnt ? REQ_FETCH : (lsu_gnt ? REQ_LSU : REQ_DBG);
        if (q_gnt.size() == 0) check("gnt_unexpected", 32'(act_id), 32'(REQ_NONE));
        else begin
          e = q_gnt.pop_front();
          check("gnt_id", 32'(act_id), 32'(e.id));
          check("mem_index", 32'(mem_index), 32'(e.idx));
          check("mem_load_en", 32'(mem_load_en), 32'(e.en));
          check("mem_load", 32'(mem_load), 32'(e.load));
          pend_rv  = (e.id == REQ_LSU) && e.rd;
          pend_drv = (e.id == REQ_DBG) && e.rd;
          pend_err = e.err;
        end
      end
    end
  end

  // Requester tasks: called just after a posedge, return just after the posedge ending the grant.
  task automatic fetch_access(input reg_word_t d, input int max_wait);
    int waited = 0;
    fetch_req = 1'b1; fetch_wdata = d;
    @(negedge clk);
    while (!fetch_gnt && waited < 20) begin waited++; @(negedge clk); end
    if (!fetch_gnt) check("fetch_gnt_timeout", 32'(fetch_gnt), 32'd1);
    check("fetch_wait", 32'(waited <= max_wait), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic lsu_access(input logic we, input reg_idx_t idx, input reg_word_t d, input int max_wait);
    int waited = 0;
    lsu_req = 1'b1; lsu_we = we; lsu_idx = idx; lsu_wdata = d;
    @(negedge clk);
    while (!lsu_gnt && waited < 20) begin waited++; @(negedge clk); end
    if (!lsu_gnt) check("lsu_gnt_timeout", 32'(lsu_gnt), 32'd1);
    check("lsu_wait", 32'(waited <= max_wait), 32'd1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

`ifdef REGARB_DEBUG_PORT_EN
  task automatic dbg_access(input logic we, input reg_idx_t idx, input reg_word_t d, input int max_wait);
    int waited = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_idx = idx; dbg_wdata = d;
    @(negedge clk);
    while (!dbg_gnt && waited < 20) begin waited++; @(negedge clk); end
    if (!dbg_gnt) check("dbg_gnt_timeout", 32'(dbg_gnt), 32'd1);
    check("dbg_wait", 32'(waited <= max_wait), 32'd1);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rf[5] = 16'h1234;
    rst = 1'b1;
    fetch_req = 1'b0; fetch_wdata = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_idx = '0; lsu_wdata = '0;
    lsu_rsv = 1'b0; lsu_rsv_idx = '0;
    alu_rs1_i = '0; alu_rs2_i = '0; alu_rd_i = '0;
`ifdef REGARB_DEBUG_PORT_EN
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_idx = '0; dbg_wdata = '0;
`endif
    #3;
    check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    check("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
    check("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    check("rst_lsu_err", 32'(lsu_err), 32'd0);
    check("rst_mem_load_en", 32'(mem_load_en), 32'd0);
    check("rst_mem_index", 32'(mem_index), 32'd0);
    check("rst_mem_load", 32'(mem_load), 32'd0);
    check("rst_lsu_rdata", 32'(lsu_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch and LSU read of r5 together: fetch first, LSU next, data one cycle later.
    exp_gnt(REQ_FETCH, 4'd0, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    exp_gnt(REQ_LSU,   4'd5, 1'b0, 16'h0000, 1'b1, 1'b0);
    q_rd.push_back(16'h1234);
    fork
      fetch_access(16'hA5A5, 0);
      lsu_access(1'b0, 4'd5, 16'h0000, 1);
    join
    check("idle_mem_index_hold", 32'(mem_index), 32'd5);
    check("idle_mem_load_en", 32'(mem_load_en), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Fetch held continuously against two LSU writes: strict alternation.
    exp_gnt(REQ_FETCH, 4'd0, 1'b1, 16'h1111, 1'b0, 1'b0);
    exp_gnt(REQ_LSU,   4'd2, 1'b1, 16'h2222, 1'b0, 1'b0);
    exp_gnt(REQ_FETCH, 4'd0, 1'b1, 16'h1112, 1'b0, 1'b0);
    exp_gnt(REQ_LSU,   4'd3, 1'b1, 16'h3333, 1'b0, 1'b0);
    exp_gnt(REQ_FETCH, 4'd0, 1'b1, 16'h1113, 1'b0, 1'b0);
    fork
      begin
        fetch_access(16'h1111, 1);
        fetch_access(16'h1112, 1);
        fetch_access(16'h1113, 1);
      end
      begin
        lsu_access(1'b1, 4'd2, 16'h2222, 1);
        lsu_access(1'b1, 4'd3, 16'h3333, 1);
      end
    join
    repeat (2) @(posedge clk); #1;

    // Scoreboard: reserving r0 is ignored, r7 reservation stalls all three operand paths.
    lsu_rsv = 1'b1; lsu_rsv_idx = 4'd0;
    @(posedge clk); #1;
    lsu_rsv = 1'b0;
    check("rsv0_ignored", 32'(busy), 32'd0);
    lsu_rsv = 1'b1; lsu_rsv_idx = 4'd7; alu_rs2_i = 4'd7;
    check("stall_before_rsv", 32'(alu_stall), 32'd0);
    @(posedge clk); #1;
    lsu_rsv = 1'b0;
    check("busy7_set", 32'(busy), 32'h0080);
    check("stall_rs2", 32'(alu_stall), 32'd1);
    alu_rs2_i = 4'd0; alu_rs1_i = 4'd7; #1;
    check("stall_rs1", 32'(alu_stall), 32'd1);
    alu_rs1_i = 4'd0; alu_rd_i = 4'd7; #1;
    check("stall_rd", 32'(alu_stall), 32'd1);
    alu_rd_i = 4'd0; #1;
    check("stall_idx0", 32'(alu_stall), 32'd0);
    alu_rs2_i = 4'd7;
    @(posedge clk); #1;
    check("stall_held", 32'(alu_stall), 32'd1);
    exp_gnt(REQ_LSU, 4'd7, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    lsu_access(1'b1, 4'd7, 16'hBEEF, 0);
    check("busy7_clr", 32'(busy), 32'd0);
    check("stall_clr", 32'(alu_stall), 32'd0);
    alu_rs2_i = 4'd0;

    // LSU write to IR: granted, write suppressed, error pulse next cycle.
    exp_gnt(REQ_LSU, 4'd0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    lsu_access(1'b1, 4'd0, 16'hFFFF, 0);
    @(posedge clk); #1;
    check("ir_not_written", 32'(rf[0]), 32'h1113);

    // Reserve and clear of r3 in the same cycle: reserve wins; a later write clears.
    lsu_rsv = 1'b1; lsu_rsv_idx = 4'd3;
    exp_gnt(REQ_LSU, 4'd3, 1'b1, 16'h3030, 1'b0, 1'b0);
    lsu_access(1'b1, 4'd3, 16'h3030, 0);
    lsu_rsv = 1'b0;
    check("busy3_set_wins", 32'(busy), 32'h0008);
    exp_gnt(REQ_LSU, 4'd3, 1'b1, 16'h3131, 1'b0, 1'b0);
    lsu_access(1'b1, 4'd3, 16'h3131, 0);
    check("busy3_clr", 32'(busy), 32'd0);

    // Reset asserted inside an LSU read grant cycle.
    lsu_rsv = 1'b1; lsu_rsv_idx = 4'd9;
    @(posedge clk); #1;
    lsu_rsv = 1'b0;
    check("busy9_set", 32'(busy), 32'h0200);
    exp_gnt(REQ_LSU, 4'd5, 1'b0, 16'h0000, 1'b1, 1'b0);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_idx = 4'd5; lsu_wdata = '0;
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("arst_lsu_gnt", 32'(lsu_gnt), 32'd0);
    check("arst_mem_index", 32'(mem_index), 32'd0);
    check("arst_mem_load_en", 32'(mem_load_en), 32'd0);
    check("arst_mem_load", 32'(mem_load), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_lsu_rdata", 32'(lsu_rdata), 32'd0);
    lsu_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("post_rst_rvalid", 32'(lsu_rvalid), 32'd0);

`ifdef REGARB_DEBUG_PORT_EN
    // LSU and debug alternate under continuous requests; debug may write IR.
    exp_gnt(REQ_LSU, 4'd7, 1'b0, 16'h0000, 1'b1, 1'b0);
    exp_gnt(REQ_DBG, 4'd5, 1'b0, 16'h0000, 1'b1, 1'b0);
    exp_gnt(REQ_LSU, 4'd2, 1'b0, 16'h0000, 1'b1, 1'b0);
    exp_gnt(REQ_DBG, 4'd2, 1'b0, 16'h0000, 1'b1, 1'b0);
    q_rd.push_back(16'hBEEF);
    q_rd.push_back(16'h2222);
    q_drd.push_back(16'h1234);
    q_drd.push_back(16'h2222);
    fork
      begin
        lsu_access(1'b0, 4'd7, 16'h0000, 1);
        lsu_access(1'b0, 4'd2, 16'h0000, 1);
      end
      begin
        dbg_access(1'b0, 4'd5, 16'h0000, 1);
        dbg_access(1'b0, 4'd2, 16'h0000, 1);
      end
    join
    exp_gnt(REQ_DBG, 4'd0, 1'b1, 16'h0D0D, 1'b0, 1'b0);
    dbg_access(1'b1, 4'd0, 16'h0D0D, 0);
    repeat (2) @(posedge clk); #1;
    check("dbg_ir_written", 32'(rf[0]), 32'h0D0D);
`endif

    repeat (3) @(posedge clk); #1;
    check("gnt_queue_drained", 32'(q_gnt.size()), 32'd0);
    check("rd_queue_drained", 32'(q_rd.size()), 32'd0);
    check("drd_queue_drained", 32'(q_drd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
